keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 10 +
 rtl/keypad_code_lut.sv | 9 +
 rtl/keypad_scanner.sv | 108 ++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, key-code constants and default parameters shared by the keypad scanner files.
package keypad_pkg;
  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_DEBOUNCE = 4;
  localparam int DEF_REPEAT_CYCLES = 64;
endpackage

// File: rtl/keypad_code_lut.sv
// keypad_code_lut: column/row position to key code; digits run row-major, bottom row is *, 0, #.
module keypad_code_lut import keypad_pkg::*; (
  input  logic [1:0] col,
  input  logic [1:0] row,
  output logic [3:0] code
);
  always_comb code = row == 2'd3 ? (col == 2'd0 ? KEY_STAR : col == 2'd1 ? 4'd0 : KEY_HASH)
                                 : {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x4 matrix keypad scanner with debounce, one-cycle valid pulse and key-down level.
// Define KEYPAD_REPEAT_EN to re-pulse V every REPEAT_CYCLES cycles while a key stays held.
module keypad_scanner import keypad_pkg::*; #(
  parameter int SETTLE        = DEF_SETTLE,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       R0,
  input  logic       R1,
  input  logic       R2,
  input  logic       R3,
  output logic       C0,
  output logic       C1,
  output logic       C2,
  output logic       V,
  output logic [3:0] N,
  output logic       Kd
);
  if (SETTLE < 1 || SETTLE > 15 || DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end
  state_t     state;
  logic [2:0] cols, nxt;
  logic [3:0] rows, pat, dwell, cnt, code;
  assign rows = {R3, R2, R1, R0};
  assign {C2, C1, C0} = cols;
  assign nxt = {cols[1:0], cols[2]};
  // pat is one-hot once latched, so the row index is a plain encode of it
  keypad_code_lut u_lut (
    .col ({cols[2], cols[1]}),
    .row ({pat[3] | pat[2], pat[3] | pat[1]}),
    .code(code)
  );
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep;
`endif
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      state <= S_SCAN;
      cols  <= 3'b001;
      dwell <= '0;
      cnt   <= '0;
      pat   <= '0;
      V     <= 1'b0;
      N     <= KEY_NONE;
      Kd    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep   <= '0;
`endif
    end else begin
      V <= 1'b0;
      case (state)
        S_SCAN:
          if (dwell != 4'(SETTLE - 1)) dwell <= dwell + 4'd1;
          else begin
            dwell <= '0;
            if ($onehot(rows)) begin
              pat   <= rows;
              cnt   <= '0;
              state <= S_DEBOUNCE;
            end else cols <= nxt;
          end
        S_DEBOUNCE:
          if (rows != pat) begin
            cnt   <= '0;
            cols  <= nxt;
            state <= S_SCAN;
          end else if (cnt == 4'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            V     <= 1'b1;
            N     <= code;
            Kd    <= 1'b1;
            state <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep   <= '0;
`endif
          end else cnt <= cnt + 4'd1;
        S_HELD:
          if (rows == 4'd0) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep == RW'(REPEAT_CYCLES - 1)) begin
            V   <= 1'b1;
            rep <= '0;
          end else rep <= rep + 1'b1;
`endif
        S_RELEASE:
          if (rows != 4'd0) begin
            cnt   <= '0;
            state <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep   <= '0;
`endif
          end else if (cnt == 4'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            Kd    <= 1'b0;
            cols  <= nxt;
            state <= S_SCAN;
          end else cnt <= cnt + 4'd1;
        default: state <= S_SCAN;
      endcase
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus key-code scoreboard driving directed and random presses into keypad_scanner.
module tb_keypad_scanner;
  localparam int SETTLE = 2, DEB = 4, REP = 64;
  typedef struct {
    logic [3:0] code;
    int         pcyc;
    bit         steady;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, bounce = 1'b0;
  logic [11:0] pressed = '0;
  logic [3:0] rows, N;
  logic C0, C1, C2, V, Kd;
  int errors = 0, checks = 0;
  int cyc = 0, since = 0, col_start = 0, vcount = 0, kd_rise = 0, last_v = 0;
  logic [2:0] last_cols = 3'b001;
  logic last_kd = 1'b0;
  bit allow_rep = 1'b0;
  logic [3:0] rep_code = '0;
  exp_t exp_q[$];
  int digits[4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
  int seq_r[5] = '{0, 0, 0, 1, 3};
  int seq_c[5] = '{0, 1, 2, 0, 2};

  keypad_scanner dut (
    .CLK(clk), .rst(rst_n),
    .R0(rows[0]), .R1(rows[1]), .R2(rows[2]), .R3(rows[3]),
    .C0(C0), .C1(C1), .C2(C2),
    .V(V), .N(N), .Kd(Kd)
  );

  always #5 clk = ~clk;

  // a pressed key shorts its row to its column drive
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++)
      rows[r] = ~bounce & ((pressed[r*3] & C0) | (pressed[r*3+1] & C1) | (pressed[r*3+2] & C2));
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n || {C2, C1, C0} != last_cols) begin
      since = 0;
      col_start = cyc;
    end else since++;
    last_cols = {C2, C1, C0};
    if (Kd && !last_kd) kd_rise++;
    last_kd = Kd;
    if (V && rst_n) begin
      vcount++;
      if (exp_q.size() > 0) begin
        check("v_code", N, exp_q[0].code);
        if (exp_q[0].steady && exp_q[0].pcyc < col_start) check("accept_latency", since, SETTLE + DEB);
        exp_q.delete(0);
      end else if (allow_rep) begin
        check("rep_code", N, rep_code);
        check("rep_gap", cyc - last_v, REP);
      end else check("spurious_v", V, 0);
      last_v = cyc;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(int r, int c, bit st);
    exp_q.push_back('{code: 4'(digits[r][c]), pcyc: cyc, steady: st});
  endtask

  task automatic press(int r, int c, bit st);
    pressed[r*3+c] = 1'b1;
    expect_key(r, c, st);
  endtask

  task automatic wait_v(int budget);
    int v0 = vcount;
    for (int i = 0; i < budget && vcount == v0; i++) @(negedge clk);
    check("v_seen", vcount != v0, 1);
  endtask

  task automatic wait_deb(logic [2:0] mask);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = {C2, C1, C0} == mask && since == SETTLE;
    end
    check("deb_entry", found, 1);
  endtask

  task automatic release_key(int r, int c);
    pressed[r*3+c] = 1'b0;
    tick(DEB);
    check("kd_hold", Kd, 1);
    tick(1);
    check("kd_clear", Kd, 0);
  endtask

  initial begin
    int v0, kr0;
    tick(3);
    check("rst_cols", {C2, C1, C0}, 3'b001);
    check("rst_v", V, 0);
    check("rst_code", N, 15);
    check("rst_kd", Kd, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check("scan_col", {C2, C1, C0}, 3'b001 << ((k / SETTLE) % 3));
    end
    v0 = vcount;
    press(1, 1, 1'b1);
    tick(40);
    check("k5_single_v", vcount - v0, 1);
    check("k5_kd", Kd, 1);
    release_key(1, 1);
    tick(3);
    v0 = vcount;
    press(3, 2, 1'b0);
    wait_deb(3'b100);
    tick(2);
    bounce = 1'b1;
    tick(1);
    bounce = 1'b0;
    check("hash_bounce_nov", vcount - v0, 0);
    check("hash_bounce_col", {C2, C1, C0}, 3'b001);
    wait_v(40);
    release_key(3, 2);
    tick(2);
    v0 = vcount;
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    tick(40);
    check("dual_nov", vcount - v0, 0);
    expect_key(0, 0, 1'b0);
    pressed[3] = 1'b0;
    wait_v(40);
    release_key(0, 0);
    tick(2);
    v0 = vcount;
    pressed[10] = 1'b1;
    wait_deb(3'b010);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("arst_cols", {C2, C1, C0}, 3'b001);
    check("arst_v", V, 0);
    check("arst_code", N, 15);
    check("arst_kd", Kd, 0);
    tick(3);
    pressed[10] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check("arst_nov", vcount - v0, 0);
    press(3, 1, 1'b1);
    wait_v(40);
    release_key(3, 1);
    tick(2);
    kr0 = kd_rise;
    for (int i = 0; i < 5; i++) begin
      press(seq_r[i], seq_c[i], 1'b1);
      wait_v(40);
      tick(2);
      release_key(seq_r[i], seq_c[i]);
      tick(3);
    end
    check("seq_kd_toggles", kd_rise - kr0, 5);
`ifdef KEYPAD_REPEAT_EN
    v0 = vcount;
    rep_code = 4'd7;
    allow_rep = 1'b1;
    press(2, 0, 1'b1);
    tick(200);
    check("rep_pulses", (vcount - v0 == 3) || (vcount - v0 == 4), 1);
    release_key(2, 0);
    allow_rep = 1'b0;
    tick(2);
`endif
    for (int i = 0; i < 20; i++) begin
      int r, c;
      r = int'($urandom_range(3));
      c = int'($urandom_range(2));
      tick(int'($urandom_range(8)));
      press(r, c, 1'b1);
      wait_v(40);
      tick(int'($urandom_range(30, 1)));
      release_key(r, c);
    end
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
